// File: rtl/axi_w_burst_buffer.sv
// Narrow-side write buffer ahead of the upsizing data-width converter: holds each AW
// until its W burst is fully stored (or the W buffer fills), then releases W without bubbles.
module axi_w_burst_buffer #(
  parameter int unsigned AxiMaxWriteTxns = 8,
  parameter int unsigned WBufDepth       = 16,
  // Bit position of the W 'last' flag inside the packed w_chan_t.
  parameter int unsigned WLastBit        = 0,
  parameter type         aw_chan_t       = logic,
  parameter type         w_chan_t        = logic,
  parameter type         b_chan_t        = logic,
  parameter type         ar_chan_t       = logic,
  parameter type         r_chan_t        = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  // upstream (narrow master side)
  input  aw_chan_t slv_aw_i,
  input  logic     slv_aw_valid_i,
  output logic     slv_aw_ready_o,
  input  w_chan_t  slv_w_i,
  input  logic     slv_w_valid_i,
  output logic     slv_w_ready_o,
  output b_chan_t  slv_b_o,
  output logic     slv_b_valid_o,
  input  logic     slv_b_ready_i,
  input  ar_chan_t slv_ar_i,
  input  logic     slv_ar_valid_i,
  output logic     slv_ar_ready_o,
  output r_chan_t  slv_r_o,
  output logic     slv_r_valid_o,
  input  logic     slv_r_ready_i,
  // downstream (toward the converter)
  output aw_chan_t mst_aw_o,
  output logic     mst_aw_valid_o,
  input  logic     mst_aw_ready_i,
  output w_chan_t  mst_w_o,
  output logic     mst_w_valid_o,
  input  logic     mst_w_ready_i,
  input  b_chan_t  mst_b_i,
  input  logic     mst_b_valid_i,
  output logic     mst_b_ready_o,
  output ar_chan_t mst_ar_o,
  output logic     mst_ar_valid_o,
  input  logic     mst_ar_ready_i,
  input  r_chan_t  mst_r_i,
  input  logic     mst_r_valid_i,
  output logic     mst_r_ready_o
);

  // Handshake rule on every channel: a beat transfers on a rising clk_i edge where
  // valid and ready are both high; valid and payload hold steady until that edge.

  localparam int unsigned AwPtrW = (AxiMaxWriteTxns > 1) ? $clog2(AxiMaxWriteTxns) : 1;
  localparam int unsigned AwCntW = $clog2(AxiMaxWriteTxns + 1);
  localparam int unsigned WPtrW  = $clog2(WBufDepth);
  localparam int unsigned WCntW  = $clog2(WBufDepth + 1);
  localparam int unsigned CmpW   = $clog2(AxiMaxWriteTxns + WBufDepth + 1);
  localparam int unsigned WBits  = $bits(w_chan_t);

  // ---------------------------------------------------------------------------
  // Pass-through channels
  // ---------------------------------------------------------------------------
  assign mst_ar_o       = slv_ar_i;
  assign mst_ar_valid_o = slv_ar_valid_i;
  assign slv_ar_ready_o = mst_ar_ready_i;
  assign slv_r_o        = mst_r_i;
  assign slv_r_valid_o  = mst_r_valid_i;
  assign mst_r_ready_o  = slv_r_ready_i;
  assign slv_b_o        = mst_b_i;
  assign slv_b_valid_o  = mst_b_valid_i;
  assign mst_b_ready_o  = slv_b_ready_i;

  // ---------------------------------------------------------------------------
  // AW FIFO
  // ---------------------------------------------------------------------------
  aw_chan_t            aw_mem [AxiMaxWriteTxns];
  logic [AwPtrW-1:0]   aw_wr_ptr, aw_rd_ptr;
  logic [AwCntW-1:0]   aw_count;
  logic                aw_full, aw_empty, aw_push, aw_pop;

  assign aw_full        = (aw_count == AwCntW'(AxiMaxWriteTxns));
  assign aw_empty       = (aw_count == '0);
  assign slv_aw_ready_o = !aw_full;
  assign aw_push        = slv_aw_valid_i && !aw_full;
  assign aw_pop         = mst_aw_valid_o && mst_aw_ready_i;
  assign mst_aw_o       = aw_mem[aw_rd_ptr];

  function automatic logic [AwPtrW-1:0] aw_ptr_inc(input logic [AwPtrW-1:0] p);
    return (p == AwPtrW'(AxiMaxWriteTxns - 1)) ? '0 : p + AwPtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (aw_push) aw_mem[aw_wr_ptr] <= slv_aw_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      aw_count  <= '0;
    end else begin
      if (aw_push) aw_wr_ptr <= aw_ptr_inc(aw_wr_ptr);
      if (aw_pop)  aw_rd_ptr <= aw_ptr_inc(aw_rd_ptr);
      case ({aw_push, aw_pop})
        2'b10:   aw_count <= aw_count + AwCntW'(1);
        2'b01:   aw_count <= aw_count - AwCntW'(1);
        default: aw_count <= aw_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // W FIFO
  // ---------------------------------------------------------------------------
  w_chan_t             w_mem [WBufDepth];
  logic [WPtrW-1:0]    w_wr_ptr, w_rd_ptr;
  logic [WCntW-1:0]    w_count;
  logic                w_full, w_empty, w_push, w_pop;
  logic [WBits-1:0]    slv_w_bits, mst_w_bits;
  logic                w_in_last, w_out_last;

  assign w_full        = (w_count == WCntW'(WBufDepth));
  assign w_empty       = (w_count == '0);
  assign slv_w_ready_o = !w_full;
  assign w_push        = slv_w_valid_i && !w_full;
  assign w_pop         = mst_w_valid_o && mst_w_ready_i;
  assign mst_w_o       = w_mem[w_rd_ptr];
  assign slv_w_bits    = slv_w_i;
  assign mst_w_bits    = mst_w_o;
  assign w_in_last     = slv_w_bits[WLastBit];
  assign w_out_last    = mst_w_bits[WLastBit];

  function automatic logic [WPtrW-1:0] w_ptr_inc(input logic [WPtrW-1:0] p);
    return (p == WPtrW'(WBufDepth - 1)) ? '0 : p + WPtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (w_push) w_mem[w_wr_ptr] <= slv_w_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_wr_ptr <= '0;
      w_rd_ptr <= '0;
      w_count  <= '0;
    end else begin
      if (w_push) w_wr_ptr <= w_ptr_inc(w_wr_ptr);
      if (w_pop)  w_rd_ptr <= w_ptr_inc(w_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   w_count <= w_count + WCntW'(1);
        2'b01:   w_count <= w_count - WCntW'(1);
        default: w_count <= w_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst bookkeeping
  // ---------------------------------------------------------------------------
  logic [CmpW-1:0]   complete_cnt;
  logic [AwCntW-1:0] issued_cnt;
  logic              skip_last;
  logic              w_in_last_hs, w_out_last_hs;
  logic              cmp_inc, cmp_dec, set_skip;

  assign w_in_last_hs  = w_push && w_in_last;
  assign w_out_last_hs = w_pop && w_out_last;
  assign cmp_inc       = w_in_last_hs && !skip_last;
  assign cmp_dec       = aw_pop && (complete_cnt != '0);
  // An AW released by the full-buffer path owns a burst whose last beat is still upstream.
  assign set_skip      = aw_pop && (complete_cnt == '0);

  assign mst_aw_valid_o = !aw_empty && ((complete_cnt != '0) || w_full);
  assign mst_w_valid_o  = !w_empty && (issued_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      complete_cnt <= '0;
      issued_cnt   <= '0;
      skip_last    <= 1'b0;
    end else begin
      case ({cmp_inc, cmp_dec})
        2'b10:   complete_cnt <= complete_cnt + CmpW'(1);
        2'b01:   complete_cnt <= complete_cnt - CmpW'(1);
        default: complete_cnt <= complete_cnt;
      endcase
      case ({aw_pop, w_out_last_hs})
        2'b10:   issued_cnt <= issued_cnt + AwCntW'(1);
        2'b01:   issued_cnt <= issued_cnt - AwCntW'(1);
        default: issued_cnt <= issued_cnt;
      endcase
      if (set_skip) begin
        skip_last <= 1'b1;
      end else if (w_in_last_hs && skip_last) begin
        skip_last <= 1'b0;
      end
    end
  end

  a_complete_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_in_last_hs && !skip_last && (complete_cnt == '1)));

  a_issued_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_out_last_hs && !aw_pop && (issued_cnt == '0)));

endmodule

// File: tb/tb_axi_w_burst_buffer.sv
// Directed bench for axi_w_burst_buffer: pass-through vector table plus hand-written
// burst sequences, with a scoreboard on the downstream AW and W channels.
module tb_axi_w_burst_buffer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } w_beat_t;

  typedef struct {
    logic [7:0]  ar;  logic ar_v; logic ar_rdy;
    logic [7:0]  r;   logic r_v;  logic r_rdy;
    logic [7:0]  b;   logic b_v;  logic b_rdy;
    logic [29:0] exp;
  } pt_vec_t;

  // clock / reset
  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic [7:0] slv_aw, mst_aw;
  logic       slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  w_beat_t    slv_w, mst_w;
  logic       slv_w_valid, slv_w_ready, mst_w_valid, mst_w_ready;
  logic [7:0] slv_b, mst_b;
  logic       slv_b_valid, slv_b_ready, mst_b_valid, mst_b_ready;
  logic [7:0] slv_ar, mst_ar;
  logic       slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic [7:0] slv_r, mst_r;
  logic       slv_r_valid, slv_r_ready, mst_r_valid, mst_r_ready;

  axi_w_burst_buffer #(
    .AxiMaxWriteTxns (8),
    .WBufDepth       (16),
    .WLastBit        (0),
    .aw_chan_t       (logic [7:0]),
    .w_chan_t        (w_beat_t),
    .b_chan_t        (logic [7:0]),
    .ar_chan_t       (logic [7:0]),
    .r_chan_t        (logic [7:0])
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slv_aw_i       (slv_aw),
    .slv_aw_valid_i (slv_aw_valid),
    .slv_aw_ready_o (slv_aw_ready),
    .slv_w_i        (slv_w),
    .slv_w_valid_i  (slv_w_valid),
    .slv_w_ready_o  (slv_w_ready),
    .slv_b_o        (slv_b),
    .slv_b_valid_o  (slv_b_valid),
    .slv_b_ready_i  (slv_b_ready),
    .slv_ar_i       (slv_ar),
    .slv_ar_valid_i (slv_ar_valid),
    .slv_ar_ready_o (slv_ar_ready),
    .slv_r_o        (slv_r),
    .slv_r_valid_o  (slv_r_valid),
    .slv_r_ready_i  (slv_r_ready),
    .mst_aw_o       (mst_aw),
    .mst_aw_valid_o (mst_aw_valid),
    .mst_aw_ready_i (mst_aw_ready),
    .mst_w_o        (mst_w),
    .mst_w_valid_o  (mst_w_valid),
    .mst_w_ready_i  (mst_w_ready),
    .mst_b_i        (mst_b),
    .mst_b_valid_i  (mst_b_valid),
    .mst_b_ready_o  (mst_b_ready),
    .mst_ar_o       (mst_ar),
    .mst_ar_valid_o (mst_ar_valid),
    .mst_ar_ready_i (mst_ar_ready),
    .mst_r_i        (mst_r),
    .mst_r_valid_i  (mst_r_valid),
    .mst_r_ready_o  (mst_r_ready)
  );

  // scoreboard state
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_aw_q[$];
  logic [8:0] exp_w_q[$];
  int         aw_hs_q[$];
  int         w_hs_q[$];
  int         outstanding = 0;
  int         aw_acc_edge, w_acc_edge;
  logic       aw_hold = 1'b0, w_hold = 1'b0;
  logic [7:0] aw_hold_val;
  w_beat_t    w_hold_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Downstream monitor; edge number of a handshake seen here is cyc+1.
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_hold     = 1'b0;
      w_hold      = 1'b0;
      outstanding = 0;
    end else begin
      if (w_hold) check("w_stall_stable", {mst_w_valid, mst_w}, {1'b1, w_hold_val});
      if (mst_w_valid) check("w_after_aw", outstanding > 0, 1'b1);
      if (mst_w_valid && mst_w_ready) begin
        if (exp_w_q.size() == 0) fail_msg("w_unexpected");
        else check("w_payload", mst_w, exp_w_q.pop_front());
        w_hs_q.push_back(cyc + 1);
        if (mst_w.last) outstanding--;
        w_hold = 1'b0;
      end else begin
        w_hold     = mst_w_valid;
        w_hold_val = mst_w;
      end
      if (aw_hold) check("aw_stall_stable", {mst_aw_valid, mst_aw}, {1'b1, aw_hold_val});
      if (mst_aw_valid && mst_aw_ready) begin
        if (exp_aw_q.size() == 0) fail_msg("aw_unexpected");
        else check("aw_payload", mst_aw, exp_aw_q.pop_front());
        aw_hs_q.push_back(cyc + 1);
        outstanding++;
        aw_hold = 1'b0;
      end else begin
        aw_hold     = mst_aw_valid;
        aw_hold_val = mst_aw;
      end
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic send_aw(input logic [7:0] id);
    int n = 0;
    slv_aw       = id;
    slv_aw_valid = 1'b1;
    @(negedge clk);
    while (!slv_aw_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) fail_msg("aw_accept_timeout");
    else begin
      exp_aw_q.push_back(id);
      aw_acc_edge = cyc + 1;
    end
    @(posedge clk); #1;
    slv_aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] data, input logic last);
    int n = 0;
    slv_w       = '{data: data, last: last};
    slv_w_valid = 1'b1;
    @(negedge clk);
    while (!slv_w_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) fail_msg("w_accept_timeout");
    else begin
      exp_w_q.push_back({data, last});
      w_acc_edge = cyc + 1;
    end
    @(posedge clk); #1;
    slv_w_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_aw_q.size() != 0 || exp_w_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_aw_q.size() + exp_w_q.size(), 0);
    idle(2);
  endtask

  task automatic clear_hist();
    aw_hs_q.delete();
    w_hs_q.delete();
  endtask

  pt_vec_t vecs [6];
  int      e16, rel_edge, n_w0;
  logic    t5_done;

  initial begin
    vecs[0] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
                {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1,
                {8'h5A, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1}};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0,
                {8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0}};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1,
                {8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1}};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b1,
                {8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b1}};
    vecs[5] = '{8'h96, 1'b1, 1'b0, 8'h69, 1'b0, 1'b1, 8'h24, 1'b0, 1'b0,
                {8'h96, 1'b1, 1'b0, 8'h69, 1'b0, 1'b1, 8'h24, 1'b0, 1'b0}};

    slv_aw = '0; slv_aw_valid = 1'b0; slv_w = '0; slv_w_valid = 1'b0;
    slv_b_ready = 1'b0; slv_ar = '0; slv_ar_valid = 1'b0; slv_r_ready = 1'b0;
    mst_aw_ready = 1'b0; mst_w_ready = 1'b0; mst_b = '0; mst_b_valid = 1'b0;
    mst_ar_ready = 1'b0; mst_r = '0; mst_r_valid = 1'b0;
    t5_done = 1'b0;

    // reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mst_aw_valid", mst_aw_valid, 1'b0);
    check("rst_mst_w_valid", mst_w_valid, 1'b0);
    check("rst_slv_aw_ready", slv_aw_ready, 1'b1);
    check("rst_slv_w_ready", slv_w_ready, 1'b1);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // pass-through table
    for (int i = 0; i < 6; i++) begin
      slv_ar = vecs[i].ar; slv_ar_valid = vecs[i].ar_v; mst_ar_ready = vecs[i].ar_rdy;
      mst_r  = vecs[i].r;  mst_r_valid  = vecs[i].r_v;  slv_r_ready  = vecs[i].r_rdy;
      mst_b  = vecs[i].b;  mst_b_valid  = vecs[i].b_v;  slv_b_ready  = vecs[i].b_rdy;
      #1;
      check($sformatf("passthru_%0d", i),
            {mst_ar, mst_ar_valid, slv_ar_ready, slv_r, slv_r_valid, mst_r_ready,
             slv_b, slv_b_valid, mst_b_ready}, vecs[i].exp);
    end
    idle(1);

    // single 4-beat burst, AW first
    mst_aw_ready = 1'b1;
    mst_w_ready  = 1'b1;
    clear_hist();
    send_aw(8'h11);
    for (int i = 0; i < 4; i++) send_w(8'hA0 + 8'(i), i == 3);
    drain("t1_drain");
    check("t1_aw_edge", aw_hs_q[0], w_acc_edge + 1);
    for (int i = 0; i < 4; i++) check($sformatf("t1_w_edge_%0d", i), w_hs_q[i], w_acc_edge + 2 + i);
    check("t1_complete_cnt", dut.complete_cnt, 0);

    // W before AW
    clear_hist();
    send_w(8'h21, 1'b0);
    send_w(8'h22, 1'b1);
    idle(5);
    check("t2_no_aw_yet", mst_aw_valid, 1'b0);
    check("t2_no_w_yet", mst_w_valid, 1'b0);
    send_aw(8'h20);
    drain("t2_drain");
    check("t2_aw_edge", aw_hs_q[0], aw_acc_edge + 1);
    check("t2_w_edge_0", w_hs_q[0], aw_acc_edge + 2);
    check("t2_w_edge_1", w_hs_q[1], aw_acc_edge + 3);

    // 32-beat burst through a 16-deep buffer
    clear_hist();
    send_aw(8'h31);
    for (int i = 0; i < 32; i++) begin
      send_w(8'(i), i == 31);
      if (i == 15) e16 = w_acc_edge;
      if (i == 19) check("t3_skip_last_set", dut.skip_last, 1'b1);
    end
    drain("t3_drain");
    check("t3_aw_cut_through_edge", aw_hs_q[0], e16 + 1);
    check("t3_w_count", w_hs_q.size(), 32);
    check("t3_skip_last_clear", dut.skip_last, 1'b0);
    check("t3_complete_cnt", dut.complete_cnt, 0);

    // 8 one-beat bursts with AW held back downstream
    clear_hist();
    mst_aw_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_aw(8'h40 + 8'(i));
      send_w(8'h80 + 8'(i), 1'b1);
    end
    check("t4_aw_full", slv_aw_ready, 1'b0);
    check("t4_complete_cnt", dut.complete_cnt, 8);
    check("t4_no_w", mst_w_valid, 1'b0);
    mst_aw_ready = 1'b1;
    rel_edge = cyc + 1;
    drain("t4_drain");
    check("t4_aw_count", aw_hs_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t4_aw_edge_%0d", i), aw_hs_q[i], rel_edge + i);
    check("t4_complete_cnt_end", dut.complete_cnt, 0);

    // W ready toggling every cycle
    clear_hist();
    mst_w_ready = 1'b0;
    fork
      begin
        send_aw(8'h51);
        for (int i = 0; i < 4; i++) send_w(8'hB0 + 8'(i), i == 3);
        drain("t5_drain");
        t5_done = 1'b1;
      end
      begin
        int n = 0;
        while (!t5_done && n < 400) begin
          @(posedge clk); #1;
          mst_w_ready = ~mst_w_ready;
          n++;
        end
      end
    join
    mst_w_ready = 1'b1;
    check("t5_w_handshakes", w_hs_q.size(), 4);
    check("t5_issued_cnt", dut.issued_cnt, 0);

    // reset with buffered contents
    clear_hist();
    mst_aw_ready = 1'b0;
    send_aw(8'h61);
    send_w(8'h71, 1'b1);
    send_aw(8'h62);
    send_w(8'h72, 1'b0);
    send_w(8'h73, 1'b0);
    check("t6_pre_aw_valid", mst_aw_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_aw_valid", mst_aw_valid, 1'b0);
    check("t6_rst_w_valid", mst_w_valid, 1'b0);
    check("t6_rst_aw_ready", slv_aw_ready, 1'b1);
    check("t6_rst_w_ready", slv_w_ready, 1'b1);
    check("t6_rst_complete_cnt", dut.complete_cnt, 0);
    exp_aw_q.delete();
    exp_w_q.delete();
    idle(2);
    rst_n = 1'b1;
    mst_aw_ready = 1'b1;
    idle(1);
    clear_hist();
    send_aw(8'h91);
    send_w(8'h99, 1'b1);
    drain("t6_drain");
    check("t6_aw_count", aw_hs_q.size(), 1);
    check("t6_w_count", w_hs_q.size(), 1);
    check("t6_complete_cnt", dut.complete_cnt, 0);
    check("t6_issued_cnt", dut.issued_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
